cpu_exec_ctrl: RTL and testbench

Execution controller that sequences the OSECPU core from the board top. It owns the core's reset and a per-cycle clock-enable, so the core runs on the board clock instead of a ripple-divided clock. It provides run, pause, single-step, programmable slow-run rate, halt detection and an executed-cycle counter for the 7-segment debug display.

---
 rtl/cpu_exec_ctrl_if.sv | 24 ++
 rtl/cpu_exec_ctrl.sv | 104 ++++++++++
 tb/tb_cpu_exec_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_exec_ctrl_if.sv
// Control/status bundle between the board-level sequencer and the core execution controller.
// The master drives requests and the core halt flag; the slave drives core reset, enable and debug status.
interface cpu_exec_ctrl_if;
  logic        run_req;
  logic        halt_req;
  logic        step_req;
  logic        restart_req;
  logic [4:0]  rate_sel;
  logic        cpu_halted;
  logic        cpu_reset;
  logic        cpu_en;
  logic [2:0]  state;
  logic [31:0] exec_count;

  modport master (
    output run_req, halt_req, step_req, restart_req, rate_sel, cpu_halted,
    input  cpu_reset, cpu_en, state, exec_count
  );

  modport slave (
    input  run_req, halt_req, step_req, restart_req, rate_sel, cpu_halted,
    output cpu_reset, cpu_en, state, exec_count
  );
endinterface

// File: rtl/cpu_exec_ctrl.sv
// Execution controller for the OSECPU core: owns core reset and a per-cycle clock enable,
// with run / pause / single-step, a power-of-two slow-run prescaler and an executed-cycle counter.
module cpu_exec_ctrl #(
  parameter int RST_CYCLES = 4,
  parameter int DIV_BITS   = 24,
  parameter bit AUTORUN    = 1'b1
) (
  input logic            clk,
  input logic            reset,
  cpu_exec_ctrl_if.slave bus
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_IDLE   = 3'd1,
    S_RUN    = 3'd2,
    S_STEP   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t              state_q;
  logic [RW-1:0]       rst_cnt_q;
  logic [DIV_BITS-1:0] cnt_q;
  logic [31:0]         exec_q;

  logic [31:0]         rate_w;
  logic [31:0]         eff_rate;
  logic [DIV_BITS-1:0] mask;
  logic                match;
  logic                cpu_en;

  // Rate exponents beyond the prescaler width clamp to the full 2^DIV_BITS period.
  assign rate_w   = {27'd0, bus.rate_sel};
  assign eff_rate = (rate_w > 32'(DIV_BITS)) ? 32'(DIV_BITS) : rate_w;
  assign mask     = ~({DIV_BITS{1'b1}} << eff_rate);
  assign match    = ((cnt_q & mask) == mask);

  assign cpu_en = (state_q == S_STEP) |
                  ((state_q == S_RUN) & match & ~bus.halt_req & ~bus.cpu_halted & ~bus.restart_req);

  assign bus.cpu_en     = cpu_en;
  assign bus.cpu_reset  = (state_q == S_RESET);
  assign bus.state      = state_q;
  assign bus.exec_count = exec_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RESET;
      rst_cnt_q <= '0;
      cnt_q     <= '0;
      exec_q    <= '0;
    end else begin
      if (cpu_en) begin
        exec_q <= exec_q + 32'd1;
      end
      // restart outranks everything, including the count update above
      if (bus.restart_req) begin
        state_q   <= S_RESET;
        rst_cnt_q <= '0;
        exec_q    <= '0;
      end else begin
        case (state_q)
          S_RESET: begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
            if (rst_cnt_q == RST_LAST) begin
              state_q <= AUTORUN ? S_RUN : S_IDLE;
              cnt_q   <= '0;
            end
          end
          S_RUN: begin
            if (bus.cpu_halted) begin
              state_q <= S_HALTED;
            end else if (bus.halt_req) begin
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_IDLE: begin
            if (bus.halt_req) begin
              state_q <= S_IDLE;
            end else if (bus.step_req) begin
              state_q <= S_STEP;
            end else if (bus.run_req) begin
              state_q <= S_RUN;
              cnt_q   <= '0;
            end
          end
          S_STEP: begin
            state_q <= bus.cpu_halted ? S_HALTED : S_IDLE;
          end
          S_HALTED: begin
            state_q <= S_HALTED;
          end
          default: begin
            state_q <= S_RESET;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Directed bench for cpu_exec_ctrl: reset/autorun, pause/resume, slow rate, stepping,
// core halt, restart priority, mid-run reset and rate clamping on a narrow prescaler.
module tb_cpu_exec_ctrl;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  cpu_exec_ctrl_if bus ();
  cpu_exec_ctrl_if bus2 ();

  cpu_exec_ctrl #(.RST_CYCLES(4), .DIV_BITS(24), .AUTORUN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  cpu_exec_ctrl #(.RST_CYCLES(4), .DIV_BITS(4), .AUTORUN(1'b0)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // inputs change just after the active edge; outputs are checked at the falling edge
  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic sn();
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.run_req = 1'b0;  bus.halt_req = 1'b0;  bus.step_req = 1'b0;
    bus.restart_req = 1'b0;  bus.rate_sel = 5'd0;  bus.cpu_halted = 1'b0;
    bus2.run_req = 1'b0; bus2.halt_req = 1'b0; bus2.step_req = 1'b0;
    bus2.restart_req = 1'b0; bus2.rate_sel = 5'd0; bus2.cpu_halted = 1'b0;

    repeat (3) @(posedge clk);
    sn();
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    chk("rst_cpu_en", 32'(bus.cpu_en), 32'd0);
    chk("rst_exec", bus.exec_count, 32'd0);

    // reset and autorun
    nc(); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sn();
      chk("rst_hold", 32'(bus.cpu_reset), 32'd1);
      chk("rst_hold_en", 32'(bus.cpu_en), 32'd0);
      nc();
    end
    for (int i = 0; i < 10; i++) begin
      sn();
      chk("autorun_en", 32'(bus.cpu_en), 32'd1);
      chk("autorun_state", 32'(bus.state), 32'd2);
      nc();
    end

    // halt / resume
    bus.halt_req = 1'b1;
    sn();
    chk("run10_exec", bus.exec_count, 32'd10);
    chk("halt_same_cycle_en", 32'(bus.cpu_en), 32'd0);
    nc(); bus.halt_req = 1'b0;
    sn();
    chk("halt_state_idle", 32'(bus.state), 32'd1);
    chk("halt_exec_frozen", bus.exec_count, 32'd10);
    nc(); nc();
    sn();
    chk("idle_exec_frozen", bus.exec_count, 32'd10);
    nc(); bus.rate_sel = 5'd1; bus.run_req = 1'b1;
    sn();
    chk("resume_pre_en", 32'(bus.cpu_en), 32'd0);
    nc(); bus.run_req = 1'b0;
    sn();
    chk("resume_state", 32'(bus.state), 32'd2);
    chk("resume_cnt0_en", 32'(bus.cpu_en), 32'd0);
    nc();
    sn();
    chk("resume_cnt1_en", 32'(bus.cpu_en), 32'd1);
    nc(); bus.halt_req = 1'b1;
    sn();
    chk("resume_exec", bus.exec_count, 32'd11);
    nc(); bus.halt_req = 1'b0;
    sn();
    chk("resume_halt_idle", 32'(bus.state), 32'd1);

    // slow rate 2^3
    nc(); bus.rate_sel = 5'd3; bus.run_req = 1'b1;
    nc(); bus.run_req = 1'b0;
    for (int j = 1; j <= 24; j++) begin
      sn();
      chk($sformatf("slow_en_%0d", j), 32'(bus.cpu_en), ((j % 8) == 0) ? 32'd1 : 32'd0);
      nc();
    end
    bus.halt_req = 1'b1;
    sn();
    chk("slow_exec", bus.exec_count, 32'd14);
    nc(); bus.halt_req = 1'b0; bus.rate_sel = 5'd0;
    sn();
    chk("slow_idle", 32'(bus.state), 32'd1);

    // single steps spaced 5 cycles apart
    for (int p = 0; p < 3; p++) begin
      nc(); bus.step_req = 1'b1;
      sn();
      chk("step_req_state", 32'(bus.state), 32'd1);
      chk("step_req_en", 32'(bus.cpu_en), 32'd0);
      nc(); bus.step_req = 1'b0;
      sn();
      chk("step_state", 32'(bus.state), 32'd3);
      chk("step_en", 32'(bus.cpu_en), 32'd1);
      nc();
      sn();
      chk("step_back_idle", 32'(bus.state), 32'd1);
      chk("step_back_en", 32'(bus.cpu_en), 32'd0);
      nc(); nc();
    end
    sn();
    chk("step_exec", bus.exec_count, 32'd17);

    // step together with run from IDLE takes the step
    nc(); bus.step_req = 1'b1; bus.run_req = 1'b1;
    nc(); bus.step_req = 1'b0; bus.run_req = 1'b0;
    sn();
    chk("step_vs_run_state", 32'(bus.state), 32'd3);
    chk("step_vs_run_en", 32'(bus.cpu_en), 32'd1);
    nc();
    sn();
    chk("step_vs_run_idle", 32'(bus.state), 32'd1);

    // step dropped while running, then core halt together with pause
    nc(); bus.run_req = 1'b1;
    nc(); bus.run_req = 1'b0; bus.step_req = 1'b1;
    sn();
    chk("run_step_state", 32'(bus.state), 32'd2);
    nc(); bus.step_req = 1'b0;
    sn();
    chk("run_step_dropped", 32'(bus.state), 32'd2);
    chk("run_step_en", 32'(bus.cpu_en), 32'd1);
    nc(); bus.cpu_halted = 1'b1; bus.halt_req = 1'b1;
    sn();
    chk("corehalt_en", 32'(bus.cpu_en), 32'd0);
    chk("corehalt_exec", bus.exec_count, 32'd20);
    nc(); bus.halt_req = 1'b0; bus.cpu_halted = 1'b0;
    sn();
    chk("corehalt_state", 32'(bus.state), 32'd4);
    for (int i = 0; i < 20; i++) begin
      nc();
      bus.run_req  = i[0];
      bus.step_req = ((i % 5) == 0);
      sn();
      chk("halted_ignore", 32'(bus.state), 32'd4);
      chk("halted_en", 32'(bus.cpu_en), 32'd0);
    end
    nc(); bus.run_req = 1'b0; bus.step_req = 1'b0;
    sn();
    chk("halted_exec", bus.exec_count, 32'd20);

    // restart, then restart again in the final reset cycle
    nc(); bus.restart_req = 1'b1;
    sn();
    chk("restart_pre_state", 32'(bus.state), 32'd4);
    nc(); bus.restart_req = 1'b0;
    sn();
    chk("restart_state", 32'(bus.state), 32'd0);
    chk("restart_exec", bus.exec_count, 32'd0);
    chk("restart_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    nc(); nc(); nc(); bus.restart_req = 1'b1;
    sn();
    chk("restart_last_rst", 32'(bus.cpu_reset), 32'd1);
    nc(); bus.restart_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sn();
      chk("restart_extend", 32'(bus.cpu_reset), 32'd1);
      nc();
    end
    sn();
    chk("restart_run_state", 32'(bus.state), 32'd2);
    chk("restart_run_en", 32'(bus.cpu_en), 32'd1);
    chk("restart_run_rst", 32'(bus.cpu_reset), 32'd0);

    // mid-run reset, then clamp check on the narrow instance
    nc(); nc(); reset = 1'b1;
    nc(); reset = 1'b0;
    sn();
    chk("midreset_state", 32'(bus.state), 32'd0);
    chk("midreset_exec", bus.exec_count, 32'd0);
    chk("midreset_en", 32'(bus.cpu_en), 32'd0);
    nc(); nc(); nc(); nc();
    sn();
    chk("noauto_idle", 32'(bus2.state), 32'd1);
    chk("auto_run", 32'(bus.state), 32'd2);
    bus2.rate_sel = 5'd31; bus2.run_req = 1'b1;
    for (int j = 1; j <= 32; j++) begin
      nc();
      if (j == 1) bus2.run_req = 1'b0;
      sn();
      chk($sformatf("clamp_en_%0d", j), 32'(bus2.cpu_en), ((j % 16) == 0) ? 32'd1 : 32'd0);
    end
    nc();
    sn();
    chk("clamp_exec", bus2.exec_count, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
